// File: rtl/mem_port_arbiter_if.sv
// Bundles the port I, port D and memory-side handshakes of mem_port_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_port_arbiter_if;
  logic        i_read;
  logic [15:0] i_address;
  logic        i_resp;
  logic [15:0] i_rdata;

  logic        d_read;
  logic        d_write;
  logic [1:0]  d_byte_enable;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic        d_resp;
  logic [15:0] d_rdata;

  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_byte_enable, d_address, d_wdata,
    input  mem_resp, mem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address,
    output d_read, d_write, d_byte_enable, d_address, d_wdata,
    output mem_resp, mem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch I / data D) arbiter in front of a single 16-bit unified memory.
// Define MEM_ARB_PERF_CNT_EN to add grant/conflict performance counters.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [15:0] perf_i_grants,
  output logic [15:0] perf_d_grants,
  output logic [15:0] perf_conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        i_resp_q, i_resp_d;
  logic        d_resp_q, d_resp_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;

  logic i_req, d_req;
  logic grant_i, grant_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    read_d     = read_q;
    write_d    = write_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_resp_d   = 1'b0;
    d_resp_d   = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // D has priority unless I has already lost MAX_WAIT grants in a row
        if (i_req && (!d_req || (wait_cnt_q == MAX_WAIT_C))) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end

        if (grant_i) begin
          state_d    = GRANT_I;
          read_d     = 1'b1;
          write_d    = 1'b0;
          be_d       = 2'b11;
          addr_d     = bus.i_address;
          wdata_d    = 16'h0000;
          wait_cnt_d = 4'd0;
        end else if (grant_d) begin
          state_d = GRANT_D;
          // read+write together is treated as a write
          write_d = bus.d_write;
          read_d  = ~bus.d_write;
          be_d    = bus.d_byte_enable;
          addr_d  = bus.d_address;
          wdata_d = bus.d_wdata;
          if (i_req && (wait_cnt_q != MAX_WAIT_C)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
      end

      GRANT_I: begin
        if (bus.mem_resp) begin
          i_rdata_d = bus.mem_rdata;
          i_resp_d  = 1'b1;
          read_d    = 1'b0;
          write_d   = 1'b0;
          state_d   = RELEASE;
        end
      end

      GRANT_D: begin
        if (bus.mem_resp) begin
          d_rdata_d = bus.mem_rdata;
          d_resp_d  = 1'b1;
          read_d    = 1'b0;
          write_d   = 1'b0;
          state_d   = RELEASE;
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      be_q       <= 2'b00;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      i_resp_q   <= 1'b0;
      d_resp_q   <= 1'b0;
      i_rdata_q  <= 16'h0000;
      d_rdata_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      read_q     <= read_d;
      write_q    <= write_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_resp_q   <= i_resp_d;
      d_resp_q   <= d_resp_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Memory side is driven purely from the captured request registers
  assign bus.mem_read        = read_q;
  assign bus.mem_write       = write_q;
  assign bus.mem_byte_enable = be_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_wdata       = wdata_q;

  assign bus.i_resp  = i_resp_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_resp  = d_resp_q;
  assign bus.d_rdata = d_rdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] perf_i_q, perf_i_d;
  logic [15:0] perf_d_q, perf_d_d;
  logic [15:0] perf_c_q, perf_c_d;

  always_comb begin
    perf_i_d = perf_i_q;
    perf_d_d = perf_d_q;
    perf_c_d = perf_c_q;
    if (grant_i) begin
      perf_i_d = perf_i_q + 16'd1;
    end
    if (grant_d) begin
      perf_d_d = perf_d_q + 16'd1;
    end
    if ((state_q == IDLE) && i_req && d_req) begin
      perf_c_d = perf_c_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_q <= 16'd0;
      perf_d_q <= 16'd0;
      perf_c_q <= 16'd0;
    end else begin
      perf_i_q <= perf_i_d;
      perf_d_q <= perf_d_d;
      perf_c_q <= perf_c_d;
    end
  end

  assign perf_i_grants  = perf_i_q;
  assign perf_d_grants  = perf_d_q;
  assign perf_conflicts = perf_c_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 16-bit byte-addressed unified memory between an instruction-fetch requester (port I) and a data-access requester (port D).
- Uses the same read/write/byte_enable/resp handshake on all three sides.
- Sits between the CPU datapath's fetch and MEM-stage interfaces and the memory model.
- Latches the winning request, holds it stable toward memory, and routes resp/rdata back only to the granted port.

Parameters:
- MAX_WAIT, 3, number of consecutive grants port I may lose to port D before port I is forced to win the next arbitration (starvation guard); legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- i_read  input  1  port I read request; held until i_resp
- i_address  input  16  port I byte address
- i_resp  output  1  one-cycle completion pulse to port I
- i_rdata  output  16  read data to port I; valid when i_resp=1
- d_read  input  1  port D read request; held until d_resp
- d_write  input  1  port D write request; held until d_resp
- d_byte_enable  input  2  port D byte lanes; [1]=high byte, [0]=low byte
- d_address  input  16  port D byte address
- d_wdata  input  16  port D write data
- d_resp  output  1  one-cycle completion pulse to port D
- d_rdata  output  16  read data to port D; valid when d_resp=1
- mem_read  output  1  read strobe to memory
- mem_write  output  1  write strobe to memory
- mem_byte_enable  output  2  byte lanes to memory
- mem_address  output  16  address to memory
- mem_wdata  output  16  write data to memory
- mem_resp  input  1  memory completion pulse
- mem_rdata  input  16  memory read data

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- Reset (async, any state): state=IDLE; all mem_* outputs 0; i_resp=d_resp=0; i_rdata=d_rdata=0; wait counter=0.
- IDLE arbitration, evaluated at each rising edge:
  - Port I request = i_read. Port D request = d_read|d_write.
  - Only one requesting: that port wins.
  - Both requesting: D wins, unless wait counter == MAX_WAIT, in which case I wins.
  - A winner's address, byte_enable, wdata and op are captured into registers.
  - Port I captures byte_enable=2'b11, wdata=0, write=0.
  - If D asserts read and write together, the captured op is write.
- mem_* outputs are driven only from the captured registers.
  - They are asserted from the first cycle in GRANT_x.
  - Requester input changes during a grant have no effect.
- GRANT_x: hold mem_read/mem_write steady until mem_resp=1.
  - On mem_resp, register mem_rdata into x_rdata and pulse x_resp for exactly one cycle (the cycle after mem_resp).
  - Go to RELEASE.
- RELEASE (one cycle):
  - mem_read=mem_write=0, so the memory returns to idle.
  - Next state is IDLE.
  - A requester must drop its request in the cycle x_resp is high; a request still high in IDLE is a new access.
- Minimum turnaround: request sampled → mem strobe next cycle → memory latency → resp pulse 1 cycle after mem_resp. Back-to-back grants are separated by RELEASE plus IDLE, i.e. at least 2 cycles of deasserted mem strobes.
- Wait counter (4 bits):
  - +1 (saturating at MAX_WAIT) when D wins while I is requesting.
  - Cleared when I wins.
  - Unchanged otherwise.
- rdata to the non-granted port holds its previous value. The resp outputs never assert simultaneously.
- mem_resp seen in IDLE or RELEASE: ignored.
- Reset mid-grant: strobes drop immediately; no resp is issued; the requester re-issues after reset.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- With macro, adds outputs:
  - perf_i_grants (16 bits): counts entries into GRANT_I.
  - perf_d_grants (16 bits): counts entries into GRANT_D.
  - perf_conflicts (16 bits): counts IDLE cycles where both ports request.
  - All three wrap at 16'hFFFF→0 and reset to 0.
- Without macro: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- I-only read at 16'h0040, memory returns 16'h1234 → exactly one mem_read access with mem_address=16'h0040, mem_byte_enable=2'b11; i_resp for one cycle with i_rdata=16'h1234; d_resp stays 0.
- D write 16'hABCD to 16'h0101 with d_byte_enable=2'b01, then D read of 16'h0100 → mem_address=16'h0101, mem_wdata=16'hABCD, mem_write=1, mem_byte_enable=2'b01; the read returns low byte 8'hCD in d_rdata[7:0].
- I and D requesting in the same cycle, counter=0 → D served first; I served next. Strobes are low for at least 2 cycles between the two accesses.
- I continuously requesting while D issues 5 back-to-back requests, MAX_WAIT=3 → grant order D,D,D,I,D,D; counter clears after the I grant.
- D changes d_address from 16'h0200 to 16'h0300 mid-grant → mem_address stays 16'h0200 until RELEASE.
- rst asserted while in GRANT_D with mem_write=1 → mem_write=0 asynchronously, no d_resp; after release, a fresh I read completes normally. With MEM_ARB_PERF_CNT_EN, counters read 0 after reset.
